// File: rtl/ptw_arbiter_nway.sv
// ptw_arbiter_nway
// Merges NUM_MASTERS page-table-walk request ports onto one DCache PTW slave
// port. An owner is locked from grant until the DCache ack, so exactly one
// walk is outstanding. Grant and response both pass through with 0 cycles of
// added latency. Priority is fixed (lowest index wins) or round-robin.
//
// Optional feature macro: PTW_ARB_PERF_EN adds per-master saturating grant
// counters and the grant_cnt_o port.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   m_req_i      per-master request level, held until that master's ack
//   m_addr_i     packed per-master address, master i at [i*ADDR_W +: ADDR_W]
//   m_data_o     response data broadcast to all masters (= s_data_i)
//   m_ack_o      one-hot ack pulse to the owning master
//   s_req_o      request to DCache
//   s_addr_o     address to DCache
//   s_data_i     DCache response data, valid with s_ack_i
//   s_ack_i      DCache ack pulse
//   busy_o       1 while an owner is locked
//   owner_o      index of current/last owner
//   grant_cnt_o  packed per-master grant counters (PTW_ARB_PERF_EN only)
//
// States
//   IDLE | no owner; arbitrate among requests, grant in the same cycle
//   BUSY | owner locked; forward owner request until DCache acks
module ptw_arbiter_nway #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_EN       = 1,
  parameter int CNT_W       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr_i,
  output logic [DATA_W-1:0]                 m_data_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic                              s_req_o,
  output logic [ADDR_W-1:0]                 s_addr_o,
  input  logic [DATA_W-1:0]                 s_data_i,
  input  logic                              s_ack_i,
  output logic                              busy_o,
  output logic [$clog2(NUM_MASTERS)-1:0]    owner_o
`ifdef PTW_ARB_PERF_EN
  ,
  output logic [NUM_MASTERS*CNT_W-1:0]      grant_cnt_o
`endif
);

  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OW-1:0] winner;
  logic [OW-1:0] sel;
  logic          any_req;
  logic          found;
  int            idx;

  assign any_req = |m_req_i;

  // Winner search. Round-robin starts one past the last winner and wraps;
  // fixed priority simply scans from index 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (RR_EN != 0) idx = (int'(rr_ptr_q) + 1 + i) % NUM_MASTERS;
      else            idx = i;
      if (!found && m_req_i[idx[OW-1:0]]) begin
        found  = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  // In IDLE the combinational winner drives the slave port directly so the
  // grant costs no cycle; in BUSY the locked owner does.
  assign sel = (state_q == ST_IDLE) ? winner : owner_q;

  always_comb begin
    s_addr_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel == OW'(i)) s_addr_o = m_addr_i[i*ADDR_W +: ADDR_W];
    end
  end

  assign s_req_o  = (state_q == ST_IDLE) ? any_req : m_req_i[owner_q];
  assign m_data_o = s_data_i;

  // Acks arriving in IDLE have no owner and are dropped.
  always_comb begin
    m_ack_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_ack_o[i] = (state_q == ST_BUSY) && (owner_q == OW'(i)) && s_ack_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_BUSY;
          owner_d  = winner;
          rr_ptr_d = winner;
        end
      end
      ST_BUSY: begin
        if (s_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign busy_o  = (state_q == ST_BUSY);
  assign owner_o = owner_q;

`ifdef PTW_ARB_PERF_EN
  logic [NUM_MASTERS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((state_q == ST_IDLE) && any_req && (winner == OW'(i)) &&
          (cnt_q[i] != {CNT_W{1'b1}}))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign grant_cnt_o = cnt_q;
`endif

`ifndef SYNTHESIS
  // A master may not withdraw its request before its own ack.
  a_no_abort: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_BUSY) |-> m_req_i[owner_q]);
`endif

endmodule

// File: tb/tb_ptw_arbiter_nway.sv
module tb_ptw_arbiter_nway;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   err_cnt;

  // 2-master fixed-priority instance
  logic [1:0]  f_req;
  logic [63:0] f_addr;
  logic [31:0] f_sdata;
  logic        f_sack;
  logic [31:0] f_mdata;
  logic [1:0]  f_mack;
  logic        f_sreq;
  logic [31:0] f_saddr;
  logic        f_busy;
  logic [0:0]  f_owner;

  // 4-master round-robin instance
  logic [3:0]   r_req;
  logic [127:0] r_addr;
  logic [31:0]  r_sdata;
  logic         r_sack;
  logic [31:0]  r_mdata;
  logic [3:0]   r_mack;
  logic         r_sreq;
  logic [31:0]  r_saddr;
  logic         r_busy;
  logic [1:0]   r_owner;

`ifdef PTW_ARB_PERF_EN
  logic [31:0] f_cnt;
  logic [63:0] r_cnt;
  logic [31:0] s_mdata;
  logic [1:0]  s_mack;
  logic        s_sreq;
  logic [31:0] s_saddr;
  logic        s_busy;
  logic [0:0]  s_owner;
  logic [3:0]  s_cnt;
`endif

  ptw_arbiter_nway #(.NUM_MASTERS(2), .RR_EN(0)) u_fix (
    .clk(clk), .rst(rst), .m_req_i(f_req), .m_addr_i(f_addr),
    .m_data_o(f_mdata), .m_ack_o(f_mack), .s_req_o(f_sreq), .s_addr_o(f_saddr),
    .s_data_i(f_sdata), .s_ack_i(f_sack), .busy_o(f_busy), .owner_o(f_owner)
`ifdef PTW_ARB_PERF_EN
    , .grant_cnt_o(f_cnt)
`endif
  );

  ptw_arbiter_nway #(.NUM_MASTERS(4), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .m_req_i(r_req), .m_addr_i(r_addr),
    .m_data_o(r_mdata), .m_ack_o(r_mack), .s_req_o(r_sreq), .s_addr_o(r_saddr),
    .s_data_i(r_sdata), .s_ack_i(r_sack), .busy_o(r_busy), .owner_o(r_owner)
`ifdef PTW_ARB_PERF_EN
    , .grant_cnt_o(r_cnt)
`endif
  );

`ifdef PTW_ARB_PERF_EN
  ptw_arbiter_nway #(.NUM_MASTERS(2), .RR_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .m_req_i(f_req), .m_addr_i(f_addr),
    .m_data_o(s_mdata), .m_ack_o(s_mack), .s_req_o(s_sreq), .s_addr_o(s_saddr),
    .s_data_i(f_sdata), .s_ack_i(f_sack), .busy_o(s_busy), .owner_o(s_owner),
    .grant_cnt_o(s_cnt)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic f_txn(input int m);
    f_req[m] = 1'b1;
    tick();
    f_sack = 1'b1;
    tick();
    f_sack   = 1'b0;
    f_req[m] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    f_req = '0; f_addr = '0; f_sdata = '0; f_sack = 1'b0;
    r_req = '0; r_addr = '0; r_sdata = '0; r_sack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++; if (f_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %0h exp 0", f_busy); end
    cmp_cnt++; if (f_sreq !== 1'b0) begin err_cnt++; $display("FAIL reset_sreq: got %0h exp 0", f_sreq); end
    cmp_cnt++; if (f_mack !== 2'b00) begin err_cnt++; $display("FAIL reset_mack: got %0h exp 0", f_mack); end
    cmp_cnt++; if (r_owner !== 2'd0) begin err_cnt++; $display("FAIL reset_owner: got %0h exp 0", r_owner); end
    rst = 1'b0;
    tick();
    cmp_cnt++; if (r_busy !== 1'b0 || r_sreq !== 1'b0) begin err_cnt++; $display("FAIL idle_after_reset: got busy=%0h sreq=%0h exp 0 0", r_busy, r_sreq); end
  endtask

  task automatic test_single();
    f_addr[63:32] = 32'h8000_1000;
    f_addr[31:0]  = 32'h1111_0000;
    f_req = 2'b10;
    #1;
    cmp_cnt++; if (f_sreq !== 1'b1) begin err_cnt++; $display("FAIL single_sreq0: got %0h exp 1", f_sreq); end
    cmp_cnt++; if (f_saddr !== 32'h8000_1000) begin err_cnt++; $display("FAIL single_saddr: got %h exp 80001000", f_saddr); end
    tick();
    cmp_cnt++; if (f_busy !== 1'b1 || f_owner !== 1'b1) begin err_cnt++; $display("FAIL single_lock: got busy=%0h owner=%0h exp 1 1", f_busy, f_owner); end
    tick();
    tick();
    f_sack = 1'b1; f_sdata = 32'h2000_04CF;
    #1;
    cmp_cnt++; if (f_mack !== 2'b10) begin err_cnt++; $display("FAIL single_mack: got %b exp 10", f_mack); end
    cmp_cnt++; if (f_mdata !== 32'h2000_04CF) begin err_cnt++; $display("FAIL single_mdata: got %h exp 200004cf", f_mdata); end
    tick();
    f_sack = 1'b0; f_req = 2'b00;
    #1;
    cmp_cnt++; if (f_busy !== 1'b0 || f_mack !== 2'b00) begin err_cnt++; $display("FAIL single_release: got busy=%0h mack=%b exp 0 00", f_busy, f_mack); end
  endtask

  task automatic test_fixed_priority();
    f_addr[31:0]  = 32'hA000_0000;
    f_addr[63:32] = 32'hA100_0000;
    f_req = 2'b11;
    #1;
    cmp_cnt++; if (f_saddr !== 32'hA000_0000) begin err_cnt++; $display("FAIL fix_first_addr: got %h exp a0000000", f_saddr); end
    tick();
    cmp_cnt++; if (f_owner !== 1'b0 || f_busy !== 1'b1) begin err_cnt++; $display("FAIL fix_first_owner: got owner=%0h busy=%0h exp 0 1", f_owner, f_busy); end
    f_sack = 1'b1; f_sdata = 32'h0000_0A0A;
    #1;
    cmp_cnt++; if (f_mack !== 2'b01) begin err_cnt++; $display("FAIL fix_first_ack: got %b exp 01", f_mack); end
    tick();
    f_sack = 1'b0; f_req = 2'b10;
    #1;
    cmp_cnt++; if (f_busy !== 1'b0 || f_sreq !== 1'b1 || f_saddr !== 32'hA100_0000) begin err_cnt++; $display("FAIL fix_idle_gap: got busy=%0h sreq=%0h addr=%h exp 0 1 a1000000", f_busy, f_sreq, f_saddr); end
    tick();
    cmp_cnt++; if (f_owner !== 1'b1 || f_busy !== 1'b1) begin err_cnt++; $display("FAIL fix_second_owner: got owner=%0h busy=%0h exp 1 1", f_owner, f_busy); end
    f_sack = 1'b1;
    #1;
    cmp_cnt++; if (f_mack !== 2'b10) begin err_cnt++; $display("FAIL fix_second_ack: got %b exp 10", f_mack); end
    tick();
    f_sack = 1'b0; f_req = 2'b00;
  endtask

  task automatic test_lock();
    f_addr[31:0]  = 32'hB000_0000;
    f_addr[63:32] = 32'hB100_0000;
    f_req = 2'b10;
    tick();
    f_req = 2'b11;
    #1;
    cmp_cnt++; if (f_saddr !== 32'hB100_0000 || f_owner !== 1'b1) begin err_cnt++; $display("FAIL lock_addr0: got addr=%h owner=%0h exp b1000000 1", f_saddr, f_owner); end
    tick();
    cmp_cnt++; if (f_saddr !== 32'hB100_0000 || f_mack !== 2'b00) begin err_cnt++; $display("FAIL lock_addr1: got addr=%h mack=%b exp b1000000 00", f_saddr, f_mack); end
    f_sack = 1'b1;
    #1;
    cmp_cnt++; if (f_mack !== 2'b10) begin err_cnt++; $display("FAIL lock_ack: got %b exp 10", f_mack); end
    tick();
    f_sack = 1'b0; f_req = 2'b01;
    #1;
    cmp_cnt++; if (f_saddr !== 32'hB000_0000 || f_busy !== 1'b0) begin err_cnt++; $display("FAIL lock_next_addr: got addr=%h busy=%0h exp b0000000 0", f_saddr, f_busy); end
    tick();
    cmp_cnt++; if (f_owner !== 1'b0) begin err_cnt++; $display("FAIL lock_next_owner: got %0h exp 0", f_owner); end
    f_sack = 1'b1;
    tick();
    f_sack = 1'b0; f_req = 2'b00;
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{1, 2, 3, 0, 1};
    logic [3:0]  exp_ack;
    logic [31:0] exp_addr;
    for (int m = 0; m < 4; m++) r_addr[m*32 +: 32] = 32'hC000_0000 + m * 32'h100;
    r_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_addr = 32'hC000_0000 + exp_order[g] * 32'h100;
      exp_ack  = 4'b0001 << exp_order[g];
      #1;
      cmp_cnt++; if (r_saddr !== exp_addr) begin err_cnt++; $display("FAIL rr_addr_%0d: got %h exp %h", g, r_saddr, exp_addr); end
      tick();
      cmp_cnt++; if (r_owner !== 2'(exp_order[g])) begin err_cnt++; $display("FAIL rr_owner_%0d: got %0d exp %0d", g, r_owner, exp_order[g]); end
      r_sack = 1'b1; r_sdata = 32'hD000_0000 + g;
      #1;
      cmp_cnt++; if (r_mack !== exp_ack || r_mdata !== 32'hD000_0000 + g) begin err_cnt++; $display("FAIL rr_ack_%0d: got ack=%b data=%h exp %b %h", g, r_mack, r_mdata, exp_ack, 32'hD000_0000 + g); end
      tick();
      r_sack = 1'b0;
    end
    r_req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    f_req = 2'b01;
    tick();
    cmp_cnt++; if (f_busy !== 1'b1) begin err_cnt++; $display("FAIL rmb_busy: got %0h exp 1", f_busy); end
    rst = 1'b1; f_req = 2'b00;
    #1;
    cmp_cnt++; if (f_busy !== 1'b0) begin err_cnt++; $display("FAIL rmb_busy_rst: got %0h exp 0", f_busy); end
    rst = 1'b0;
    f_sack = 1'b1; f_sdata = 32'hDEAD_BEEF;
    #1;
    cmp_cnt++; if (f_mack !== 2'b00 || f_busy !== 1'b0) begin err_cnt++; $display("FAIL rmb_ack_dropped: got ack=%b busy=%0h exp 00 0", f_mack, f_busy); end
    tick();
    f_sack = 1'b0;
  endtask

`ifdef PTW_ARB_PERF_EN
  task automatic test_perf();
    for (int k = 0; k < 3; k++) begin
      r_req = 4'b0001;
      tick();
      r_sack = 1'b1;
      tick();
      r_sack = 1'b0; r_req = 4'b0000;
    end
    cmp_cnt++; if (r_cnt[15:0] !== 16'd3) begin err_cnt++; $display("FAIL perf_cnt0: got %0d exp 3", r_cnt[15:0]); end
    for (int k = 0; k < 5; k++) f_txn(0);
    cmp_cnt++; if (f_cnt[15:0] !== 16'd5) begin err_cnt++; $display("FAIL perf_cnt5: got %0d exp 5", f_cnt[15:0]); end
    cmp_cnt++; if (s_cnt[1:0] !== 2'd3) begin err_cnt++; $display("FAIL perf_sat: got %0d exp 3", s_cnt[1:0]); end
  endtask
`endif

  initial begin
    cmp_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_single();
    test_fixed_priority();
    test_lock();
    test_round_robin();
    test_reset_mid_busy();
`ifdef PTW_ARB_PERF_EN
    test_perf();
`endif
    f_txn(1);
    #1;
    cmp_cnt++; if (f_owner !== 1'b1 || f_busy !== 1'b0) begin err_cnt++; $display("FAIL last_owner: got owner=%0h busy=%0h exp 1 0", f_owner, f_busy); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
